r4_ibutter_seq: RTL
===================

R4_IBUTTER_SEQ -- requirements
Module: r4_ibutter_seq

Interface
REQ-001 Parameter DW, default 4, the signed two's-complement width of each real and imaginary input component.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, as listed in REQ-003 and REQ-004.
REQ-003 wb_clk_i  input  1  is the single clock; all state updates on its rising edge.
REQ-004 wb_rst_i  input  1  is the synchronous, active-high reset.
REQ-005 in_valid  input  1  means an input frequency-domain sample is presented.
REQ-006 in_ready  output  1  means the block accepts an input sample this cycle.
REQ-007 in_re, in_im  input  DW each  are the real and imaginary parts of the input sample X[k].
REQ-008 out_valid  output  1  means an output time-domain sample is presented.
REQ-009 out_ready  input  1  means the downstream consumer accepts the output sample.
REQ-010 out_re, out_im  output  DW+2 each  are the real and imaginary parts of the output sample y[n].
REQ-011 out_idx  output  2  is the index n of the current output sample.
REQ-012 busy  output  1  is high whenever the state is not LOAD, or sample_cnt is not 0.

Function
REQ-013 The block SHALL compute a 4-point inverse DFT (radix-4 inverse butterfly, twiddle +j) on four serially loaded samples X0..X3 and emit y0..y3 serially.
REQ-014 The state machine SHALL have three states: LOAD, CALC and EMIT.
REQ-015 In LOAD: in_ready=1; a transfer occurs when in_valid&in_ready; the sample is stored at sample_cnt, and sample_cnt increments.
REQ-016 After the transfer with sample_cnt==3, the machine SHALL go to CALC, and sample_cnt SHALL wrap to 0.
REQ-017 In CALC (exactly 1 cycle): in_ready=0 and out_valid=0; all four results are registered; the next state is EMIT, with out_cnt=0.
REQ-018 The results SHALL be y0=X0+X1+X2+X3 and y2=X0-X1+X2-X3.
REQ-019 y1 SHALL be computed as re=X0r-X1i-X2r+X3i and im=X0i+X1r-X2i-X3r.
REQ-020 y3 SHALL be computed as re=X0r+X1i-X2r-X3i and im=X0i-X1r-X2i+X3r.
REQ-021 Arithmetic SHALL be signed at DW+2 bits; operands are sign-extended before use, and no overflow is possible.
REQ-022 In EMIT: out_valid=1, with out_re/out_im = y[out_cnt] and out_idx = out_cnt.
REQ-023 In EMIT, outputs SHALL be held stable while out_ready=0.
REQ-024 On out_valid&out_ready, out_cnt SHALL increment; after out_cnt==3 is accepted, the machine SHALL return to LOAD.
REQ-025 Latency SHALL be: the first output is valid 2 cycles after the 4th input transfer, with a throughput of 1 output per cycle under out_ready=1.
REQ-026 in_ready SHALL be 0 in CALC and EMIT; no input is accepted while outputs are pending.
REQ-027 in_valid SHALL be ignored in CALC and EMIT, and out_ready SHALL be ignored outside EMIT.

Reset
REQ-028 While wb_rst_i=1 at a clock edge, the machine SHALL enter LOAD with sample_cnt=0 and out_cnt=0.
REQ-029 On reset: out_valid=0, out_re=0, out_im=0, out_idx=0, busy=0; stored samples and results SHALL be cleared to 0.
REQ-030 Reset mid-LOAD or mid-EMIT SHALL discard the partial frame; in_ready=1 on the first cycle after reset is released.

Configuration
REQ-031 With the macro R4_IBUTTER_SCALE_EN defined, each registered result SHALL be arithmetic-shifted right by 2 (divide by 4, floor) and sign-extended to DW+2 bits.
REQ-032 Without R4_IBUTTER_SCALE_EN, results SHALL be unscaled full-precision DW+2-bit sums; all timing is identical in both builds.

Verification
REQ-033 Impulse: X0=(4,0), X1..X3=0, out_ready=1 -> y0..y3 all (4,0) unscaled, or all (1,0) when scaled.
REQ-034 Single tone: X1=(4,0), others 0 -> y=(4,0),(0,4),(-4,0),(0,-4), with out_idx 0,1,2,3; scaled y=(1,0),(0,1),(-1,0),(0,-1).
REQ-035 Extreme: all Xk=(-8,-8) -> y0=(-32,-32), y1..y3=(0,0); scaled y0=(-8,-8); no wrap.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles during y1 -> y1 is held stable, in_ready=0 throughout, and y2 follows 1 cycle after out_ready rises.
REQ-037 Reset mid-frame: assert wb_rst_i after 2 input transfers -> busy=0 and in_ready=1; the next 4 inputs form a fresh frame with correct outputs.
REQ-038 Gapped input: toggle in_valid every other cycle -> only cycles with in_valid high are accepted; outputs match REQ-034.

Source files
------------

// File: rtl/r4_ibutter_seq.sv
// Serial 4-point inverse DFT: load X0..X3, one compute cycle, emit y0..y3 with handshakes.
// Define R4_IBUTTER_SCALE_EN to divide every result by 4 (arithmetic shift, floor).
module r4_ibutter_seq #(
    parameter int DW = 4
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW+1:0] out_re,
    output logic [DW+1:0] out_im,
    output logic [1:0]    out_idx,
    output logic          busy
);
    typedef enum logic [1:0] {LOAD, CALC, EMIT} state_t;

    state_t               state_q, state_d;
    logic [1:0]           sample_cnt_q, sample_cnt_d;
    logic [1:0]           out_cnt_q, out_cnt_d;
    logic [3:0][DW-1:0]   xr_q, xi_q;
    logic [3:0][DW+1:0]   yr_q, yi_q;

    logic signed [DW+1:0] xr_s [4];
    logic signed [DW+1:0] xi_s [4];
    logic signed [DW+1:0] sr [4];
    logic signed [DW+1:0] si [4];
    logic signed [DW+1:0] rr [4];
    logic signed [DW+1:0] ri [4];

    for (genvar k = 0; k < 4; k++) begin : g_ext
        assign xr_s[k] = {{2{xr_q[k][DW-1]}}, xr_q[k]};
        assign xi_s[k] = {{2{xi_q[k][DW-1]}}, xi_q[k]};
    end

    // Twiddle powers of +j reduce to swaps and sign flips of the operands.
    always_comb begin
        sr[0] = xr_s[0] + xr_s[1] + xr_s[2] + xr_s[3];
        si[0] = xi_s[0] + xi_s[1] + xi_s[2] + xi_s[3];
        sr[1] = xr_s[0] - xi_s[1] - xr_s[2] + xi_s[3];
        si[1] = xi_s[0] + xr_s[1] - xi_s[2] - xr_s[3];
        sr[2] = xr_s[0] - xr_s[1] + xr_s[2] - xr_s[3];
        si[2] = xi_s[0] - xi_s[1] + xi_s[2] - xi_s[3];
        sr[3] = xr_s[0] + xi_s[1] - xr_s[2] - xi_s[3];
        si[3] = xi_s[0] - xr_s[1] - xi_s[2] + xr_s[3];
        for (int k = 0; k < 4; k++) begin
`ifdef R4_IBUTTER_SCALE_EN
            rr[k] = sr[k] >>> 2;
            ri[k] = si[k] >>> 2;
`else
            rr[k] = sr[k];
            ri[k] = si[k];
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        out_cnt_d    = out_cnt_q;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        unique case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sample_cnt_d = sample_cnt_q + 2'd1;
                    if (sample_cnt_q == 2'd3) state_d = CALC;
                end
            end
            CALC: begin
                out_cnt_d = 2'd0;
                state_d   = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    out_cnt_d = out_cnt_q + 2'd1;
                    if (out_cnt_q == 2'd3) state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= LOAD;
            sample_cnt_q <= '0;
            out_cnt_q    <= '0;
            xr_q         <= '0;
            xi_q         <= '0;
            yr_q         <= '0;
            yi_q         <= '0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            out_cnt_q    <= out_cnt_d;
            if (state_q == LOAD && in_valid) begin
                xr_q[sample_cnt_q] <= in_re;
                xi_q[sample_cnt_q] <= in_im;
            end
            if (state_q == CALC) begin
                for (int k = 0; k < 4; k++) begin
                    yr_q[k] <= rr[k];
                    yi_q[k] <= ri[k];
                end
            end
        end
    end

    // Outputs read zero outside EMIT so stale results never leak.
    assign out_re  = out_valid ? yr_q[out_cnt_q] : '0;
    assign out_im  = out_valid ? yi_q[out_cnt_q] : '0;
    assign out_idx = out_cnt_q;
    assign busy    = (state_q != LOAD) || (sample_cnt_q != 2'd0);
endmodule
